// File: rtl/calc_cmd_sequencer.sv
// Command sequencer for the accumulating calculator: queues host (op, operand)
// commands, issues them back-to-back, and attributes each calc_out to its command.
module calc_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int VAL_W = 4,
  parameter int OUT_W = 9,
  parameter int LAT   = 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [VAL_W-1:0] cmd_val,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       calc_op,
  output logic [VAL_W-1:0] calc_val2,
  input  logic [OUT_W-1:0] calc_out,
  output logic             res_valid,
  output logic [OUT_W-1:0] res_data,
  output logic [IDX_W-1:0] res_idx,
  output logic [15:0]      issued_cnt,
  output logic             div0_err,
  output logic [1:0]       state_dbg
);

  // Handshake: a command is accepted on a clock edge where cmd_valid && cmd_ready;
  // cmd_valid without cmd_ready is dropped, the host need not hold it.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  state_t state_q, state_d;

  logic [VAL_W+1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_ptr, rd_ptr, run_idx;
  logic [IDX_W:0]   count;
  logic             accept, pop;

  // Tag stages 0..LAT-1 track the command through the calculator; stage LAT
  // marks the cycle whose calc_out belongs to that command.
  logic [LAT:0]     tag_v;
  logic [IDX_W-1:0] tag_idx [LAT+1];

  logic [1:0]       head_op;
  logic [VAL_W-1:0] head_val;

  assign accept    = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_ISSUE);
  assign head_op   = mem[rd_ptr][VAL_W+1:VAL_W];
  assign head_val  = mem[rd_ptr][VAL_W-1:0];
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = (count != CNT_FULL);
        if (start && ((count != '0) || accept)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (count == CNT_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tag_v == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue storage needs no reset; occupancy is governed by the pointers/count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {cmd_op, cmd_val};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      run_idx    <= '0;
      calc_op    <= 2'b00;
      calc_val2  <= '0;
      issued_cnt <= 16'd0;
      div0_err   <= 1'b0;
      tag_v      <= '0;
      for (int i = 0; i <= LAT; i++) tag_idx[i] <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_idx    <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        count  <= count + CNT_ONE;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        count      <= count - CNT_ONE;
        run_idx    <= run_idx + PTR_ONE;
        calc_op    <= head_op;
        calc_val2  <= head_val;
        issued_cnt <= issued_cnt + 16'd1;
        if (head_op == 2'b11 && head_val == '0) div0_err <= 1'b1;
      end else begin
        calc_op   <= 2'b00;
        calc_val2 <= '0;
      end
      if (state_q == S_DONE) run_idx <= '0;

      tag_v      <= {tag_v[LAT-1:0], pop};
      tag_idx[0] <= run_idx;
      for (int i = 1; i <= LAT; i++) tag_idx[i] <= tag_idx[i-1];

      res_valid <= tag_v[LAT];
      if (tag_v[LAT]) begin
        res_data <= calc_out;
        res_idx  <= tag_idx[LAT];
      end
    end
  end

endmodule
